// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg: state encoding, grant constants and direction codes shared by the memory port arbiter
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_GRANT_IC = 2'd1;
    localparam logic [1:0] ST_GRANT_DC = 2'd2;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IC   = 2'b01;
    localparam logic [1:0] GRANT_DC   = 2'b10;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    function automatic logic [1:0] grant_of(input logic [1:0] st);
        return st == ST_GRANT_IC ? GRANT_IC : st == ST_GRANT_DC ? GRANT_DC : GRANT_NONE;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: burst request/response bundle between a requester (master) and a memory port (slave)
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 22
);
    logic                  valid;
    logic                  read_write_n;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  data_read;
    logic                  last;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output valid, read_write_n, address, wr_data,
        input  rd_valid, data_read, last, rd_data
    );

    modport slave (
        input  valid, read_write_n, address, wr_data,
        output rd_valid, data_read, last, rd_data
    );

endinterface

// File: rtl/mem_port_arbiter_beat_counter.sv
// mem_arb_beat_counter: counts beats of the current burst, detects burst end and latches protocol errors
module mem_arb_beat_counter #(
    parameter int BURST_LEN      = 4,
    parameter int BEAT_CNT_WIDTH = 3
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic beat,
    input  logic last,
    input  logic idle_handshake,
    output logic burst_end,
    output logic error
);

    localparam logic [BEAT_CNT_WIDTH-1:0] LAST_IDX = BEAT_CNT_WIDTH'(BURST_LEN - 1);
    localparam logic [BEAT_CNT_WIDTH-1:0] FULL     = BEAT_CNT_WIDTH'(BURST_LEN);

    logic [BEAT_CNT_WIDTH-1:0] count;
    logic bad_end, overrun;

    assign burst_end = beat & last;
    assign bad_end   = burst_end & (count != LAST_IDX);
    assign overrun   = beat & (count == FULL);

    // beat count clears on burst end and saturates once a full burst has been seen
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            count <= '0;
        else if (burst_end)
            count <= '0;
        else if (beat && count != FULL)
            count <= count + 1'b1;
    end

    // sticky error: short/long burst or a memory handshake with nobody granted
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            error <= 1'b0;
        else if (bad_end | overrun | idle_handshake)
            error <= 1'b1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one burst memory port between i_cache and d_cache; MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed d_cache priority
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_ADDR_WIDTH = 22,
    parameter int BURST_LEN      = 4,
    parameter int BEAT_CNT_WIDTH = 3
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    mem_port_arbiter_if.slave         ic,
    mem_port_arbiter_if.slave         dc,
    mem_port_arbiter_if.master        mem,
    output logic [1:0]                o_Grant,
    output logic                      o_Error
);

    logic [1:0] state, next_state;
    logic       granted, handshake, beat, burst_end, pick_dc, sel_ic, sel_dc;

    assign granted   = state != ST_IDLE;
    assign sel_ic    = state == ST_GRANT_IC;
    assign sel_dc    = state == ST_GRANT_DC;
    assign handshake = mem.rd_valid | mem.data_read;
    assign beat      = granted & handshake;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_dc;

    assign pick_dc = dc.valid & (~ic.valid | ~last_dc);

    // remember who won the most recent arbitration so a conflict favours the other side
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            last_dc <= 1'b0;
        else if (state == ST_IDLE && (ic.valid || dc.valid))
            last_dc <= pick_dc;
    end
`else
    assign pick_dc = dc.valid;
`endif

    // arbitrate only in IDLE; an owner keeps the port until the memory signals the last beat
    always_comb begin
        next_state = state == ST_IDLE ? (pick_dc ? ST_GRANT_DC : ic.valid ? ST_GRANT_IC : ST_IDLE)
                   : burst_end        ? ST_IDLE
                   :                    state;
    end

    // registered owner; a burst end always passes through IDLE for one turnaround cycle
    always_ff @(posedge i_Clk) begin
        if (i_Reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    assign mem.valid        = sel_ic ? ic.valid        : sel_dc ? dc.valid        : 1'b0;
    assign mem.read_write_n = sel_ic ? ic.read_write_n : sel_dc ? dc.read_write_n : 1'b0;
    assign mem.address      = sel_ic ? ic.address      : sel_dc ? dc.address      : {MEM_ADDR_WIDTH{1'b0}};
    assign mem.wr_data      = sel_ic ? ic.wr_data      : sel_dc ? dc.wr_data      : {DATA_WIDTH{1'b0}};

    assign ic.rd_valid  = sel_ic & mem.rd_valid;
    assign ic.data_read = sel_ic & mem.data_read;
    assign ic.last      = sel_ic & mem.last;
    assign ic.rd_data   = mem.rd_data;

    assign dc.rd_valid  = sel_dc & mem.rd_valid;
    assign dc.data_read = sel_dc & mem.data_read;
    assign dc.last      = sel_dc & mem.last;
    assign dc.rd_data   = mem.rd_data;

    assign o_Grant = grant_of(state);

    mem_arb_beat_counter #(
        .BURST_LEN      (BURST_LEN),
        .BEAT_CNT_WIDTH (BEAT_CNT_WIDTH)
    ) u_beat_counter (
        .i_Clk          (i_Clk),
        .i_Reset        (i_Reset),
        .beat           (beat),
        .last           (mem.last),
        .idle_handshake (~granted & handshake),
        .burst_end      (burst_end),
        .error          (o_Error)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized bench for mem_port_arbiter against a transaction-level owner/burst model
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int DW  = 32;
    localparam int MAW = 22;
    localparam int BL  = 4;

    typedef struct {
        logic           rw;
        logic [MAW-1:0] addr;
    } req_t;

    logic       i_Clk = 1'b0;
    logic       i_Reset;
    logic [1:0] o_Grant;
    logic       o_Error;

    always #5 i_Clk = ~i_Clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(MAW)) ic_bus ();
    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(MAW)) dc_bus ();
    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(MAW)) mem_bus ();

    mem_port_arbiter #(
        .DATA_WIDTH     (DW),
        .MEM_ADDR_WIDTH (MAW),
        .BURST_LEN      (BL),
        .BEAT_CNT_WIDTH (3)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .ic      (ic_bus),
        .dc      (dc_bus),
        .mem     (mem_bus),
        .o_Grant (o_Grant),
        .o_Error (o_Error)
    );

    // pending cache requests; the head is presented while the queue is non-empty
    req_t ic_q[$];
    req_t dc_q[$];

    // reference model: who owns the port (0 none, 1 ic, 2 dc), beats seen, sticky error
    int owner      = 0;
    int beats      = 0;
    int last_owner = 1;
    bit err        = 0;
    int bad_last   = -1;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic owner_rw();
        return owner == 1 ? ic_q[0].rw : dc_q[0].rw;
    endfunction

    function automatic bit owner_has_req();
        return owner == 1 ? ic_q.size() != 0 : owner == 2 ? dc_q.size() != 0 : 1'b0;
    endfunction

    // apply one cycle of cache and memory stimulus just after the clock edge
    task automatic drive();
        bit hs;
        int idx;
        ic_bus.valid        = ic_q.size() != 0;
        ic_bus.read_write_n = ic_q.size() != 0 ? ic_q[0].rw : 1'b0;
        ic_bus.address      = ic_q.size() != 0 ? ic_q[0].addr : '0;
        ic_bus.wr_data      = $urandom;
        dc_bus.valid        = dc_q.size() != 0;
        dc_bus.read_write_n = dc_q.size() != 0 ? dc_q[0].rw : 1'b0;
        dc_bus.address      = dc_q.size() != 0 ? dc_q[0].addr : '0;
        dc_bus.wr_data      = $urandom;
        idx = bad_last >= 0 ? bad_last : BL - 1;
        hs  = owner_has_req() && ($urandom_range(0, 3) != 0);
        mem_bus.rd_valid  = hs && owner_rw() == READ;
        mem_bus.data_read = hs && owner_rw() == WRITE;
        mem_bus.last      = hs && beats == idx;
        mem_bus.rd_data   = $urandom;
    endtask

    // compare every output against the model, then advance the model by one clock
    task automatic tick();
        logic [1:0]     eg;
        logic           ev, erw;
        logic [MAW-1:0] ea;
        logic [DW-1:0]  ed;
        bit             hs;
        #1;
        eg  = owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00;
        ev  = owner == 1 ? ic_bus.valid : owner == 2 ? dc_bus.valid : 1'b0;
        erw = owner == 1 ? ic_bus.read_write_n : owner == 2 ? dc_bus.read_write_n : 1'b0;
        ea  = owner == 1 ? ic_bus.address : owner == 2 ? dc_bus.address : '0;
        ed  = owner == 1 ? ic_bus.wr_data : owner == 2 ? dc_bus.wr_data : '0;
        check_val("grant", o_Grant, eg);
        check_val("error", o_Error, err);
        check_val("mem_valid", mem_bus.valid, ev);
        check_val("mem_rw", mem_bus.read_write_n, erw);
        check_val("mem_addr", mem_bus.address, ea);
        check_val("mem_wdata", mem_bus.wr_data, ed);
        check_val("ic_valid", ic_bus.rd_valid, owner == 1 && mem_bus.rd_valid);
        check_val("ic_data_read", ic_bus.data_read, owner == 1 && mem_bus.data_read);
        check_val("ic_last", ic_bus.last, owner == 1 && mem_bus.last);
        check_val("dc_valid", dc_bus.rd_valid, owner == 2 && mem_bus.rd_valid);
        check_val("dc_data_read", dc_bus.data_read, owner == 2 && mem_bus.data_read);
        check_val("dc_last", dc_bus.last, owner == 2 && mem_bus.last);
        check_val("ic_rdata", ic_bus.rd_data, mem_bus.rd_data);
        check_val("dc_rdata", dc_bus.rd_data, mem_bus.rd_data);
        hs = mem_bus.rd_valid || mem_bus.data_read;
        if (i_Reset) begin
            owner = 0; beats = 0; err = 0; last_owner = 1;
            ic_q.delete(); dc_q.delete();
        end else if (owner == 0) begin
            if (hs) err = 1;
            if (ic_bus.valid && dc_bus.valid) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                owner = last_owner == 2 ? 1 : 2;
`else
                owner = 2;
`endif
            end else if (dc_bus.valid) owner = 2;
            else if (ic_bus.valid) owner = 1;
            if (owner != 0) last_owner = owner;
        end else if (hs) begin
            beats++;
            if (mem_bus.last) begin
                if (beats != BL) err = 1;
                if (owner == 1) void'(ic_q.pop_front());
                else void'(dc_q.pop_front());
                owner = 0;
                beats = 0;
            end else if (beats > BL) err = 1;
        end
        @(posedge i_Clk);
        #1;
    endtask

    task automatic step();
        drive();
        tick();
    endtask

    task automatic run_idle(input int max);
        int n = 0;
        while ((ic_q.size() != 0 || dc_q.size() != 0 || owner != 0) && n < max) begin
            step();
            n++;
        end
        check_val("drain", n < max, 1);
        step();
        step();
    endtask

    task automatic do_reset();
        i_Reset = 1'b1;
        step();
        step();
        i_Reset = 1'b0;
    endtask

    initial begin
        int n;
        i_Reset = 1'b1;
        drive();
        @(posedge i_Clk);
        #1;
        do_reset();

        // single i_cache read
        ic_q.push_back('{READ, 22'h000100});
        run_idle(100);

        // simultaneous requests from reset state
        ic_q.push_back('{READ, 22'h000200});
        dc_q.push_back('{READ, 22'h000300});
        run_idle(200);

        // d_cache owns a burst, then both contend
        dc_q.push_back('{WRITE, 22'h000400});
        run_idle(100);
        ic_q.push_back('{READ, 22'h000500});
        dc_q.push_back('{READ, 22'h000600});
        run_idle(200);

        // d_cache writeout followed by populate with valid held
        dc_q.push_back('{WRITE, 22'h0A0000});
        dc_q.push_back('{READ, 22'h1B0000});
        run_idle(200);

        // random traffic from both caches
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0 && ic_q.size() < 3)
                ic_q.push_back('{1'($urandom_range(0, 1)), MAW'($urandom)});
            if ($urandom_range(0, 7) == 0 && dc_q.size() < 3)
                dc_q.push_back('{1'($urandom_range(0, 1)), MAW'($urandom)});
            step();
        end
        run_idle(400);

        // memory ends the burst early on its second beat
        bad_last = 1;
        ic_q.push_back('{READ, 22'h002000});
        run_idle(100);
        bad_last = -1;
        dc_q.push_back('{READ, 22'h003000});
        run_idle(100);

        // reset in the middle of a burst
        ic_q.push_back('{READ, 22'h004000});
        n = 0;
        while (beats < 2 && n < 100) begin
            step();
            n++;
        end
        check_val("mid_burst_reach", n < 100, 1);
        i_Reset = 1'b1;
        step();
        i_Reset = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
